pipelined_shift_unit: RTL and testbench
=======================================

Name: pipelined_shift_unit

Overview:
- Parametrised, pipelined barrel shifter for the ALU shift path; the successor to the fixed 32-bit, single-mode combinational right-shift stages.
- Supports four modes: logical left, logical right, arithmetic right and rotate right.
- One barrel level per pipeline stage, each followed by a register. Valid/ready handshake on input and output.
- Carries a sideband tag so the issuing logic can match results to requests.

Parameters:
- WIDTH, 32, data width in bits; must be a power of 2 and at least 2.
- SHW, $clog2(WIDTH), shift-amount width; derived, not overridden.
- TAGW, 5, sideband tag width; typically the destination register index.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset; one clock; reset polarity and synchronicity are fixed.
- in_valid  in  1  request present.
- in_ready  out  1  unit accepts a request this cycle.
- in_data  in  WIDTH  operand.
- in_shamt  in  SHW  shift amount, 0..WIDTH-1.
- in_mode  in  2  00=SLL, 01=SRL, 10=SRA, 11=ROR.
- in_tag  in  TAGW  opaque sideband, returned unchanged.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- out_data  out  WIDTH  shifted result.
- out_tag  out  TAGW  tag of the result.

Behaviour:
- Pipeline depth and latency:
  - SHW levels; level k shifts by 2^k when shamt bit k is set, LSB level first.
  - Each level's output is registered; latency from accept to out_valid is exactly SHW cycles (5 at WIDTH=32).
- Per-stage registers: data, remaining shamt bits, mode, tag, valid bit.
- Fill rules per mode at each level:
  - SLL: vacated LSBs filled with 0.
  - SRL: vacated MSBs filled with 0.
  - SRA: vacated MSBs filled with the original operand MSB. The sign is carried from stage 0; it is not re-read from shifted data.
  - ROR: bits shifted out at the LSB re-enter at the MSB.
- Stall rule:
  - advance = !out_valid | out_ready; every stage loads only when advance=1.
  - in_ready = advance, combinational.
  - Global stall; no bubble collapse; no combinational path from in_valid to out_valid.
- Transfers: input accepted when in_valid & in_ready; output consumed when out_valid & out_ready.
- Throughput: one result per cycle with out_ready held high.
- Back-to-back accepts are allowed. The accept and the consume of different items in the same cycle are both honoured.
- Invalid stage contents: data and tag are don't-care but must still shift deterministically. Only the valid bits gate observability.
- Held outputs: while stalled, out_data, out_tag and out_valid hold constant.
- Reset:
  - On reset_n low, all valid bits clear immediately (asynchronous); out_valid=0.
  - out_data=0 and out_tag=0 at reset; in_ready=1 once reset is asserted.
  - In-flight requests are discarded, with no partial results.
  - Deassertion is taken synchronously by the next rising edge; the first accept is possible on the first edge after release.
- Boundary cases:
  - shamt=0 passes data unchanged in all modes.
  - shamt=WIDTH-1 with SRA yields all-sign.
  - ROR by any amount preserves the operand's popcount.
- No X propagation: out_data is driven from registers only.

Test Plan:
- WIDTH=32, SRA, 0x80000000, shamt=2, tag=7 -> after 5 cycles out_valid=1, out_data=0xE0000000, out_tag=7.
- Same operand with SRL shamt=2 -> 0x20000000; SLL of 0x00000001 shamt=31 -> 0x80000000; ROR of 0x00000001 shamt=1 -> 0x80000000.
- Throughput and order: out_ready=1, issue 8 back-to-back requests with tags 0..7 over mixed modes -> 8 results on 8 consecutive cycles starting at cycle 5, in tag order, all matching a reference model.
- Backpressure: fill the pipe, drop out_ready for 3 cycles -> in_ready=0 and out_data/out_tag stable for 3 cycles. Raise out_ready -> the stream resumes with no loss or duplication.
- Reset mid-operation: 3 requests in flight, pulse reset_n low for half a cycle between edges -> out_valid drops immediately, out_data=0, no stale results appear after release. A new request completes 5 cycles after its accept.
- Random sweep at WIDTH=8 and WIDTH=64: 10k random data, shamt and mode with random out_ready -> every result matches the scoreboard, and latency equals SHW plus stall cycles.

Source files
------------

// File: rtl/pipelined_shift_unit_if.sv
// Request/response bundle of the pipelined shift unit: valid/ready request
// channel (operand, shift amount, mode, tag) and valid/ready result channel.
interface pipelined_shift_unit_if #(
  parameter int WIDTH = 32,
  parameter int TAGW  = 5
) ();
  localparam int SHW = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SHW-1:0]   in_shamt;
  logic [1:0]       in_mode;
  logic [TAGW-1:0]  in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [TAGW-1:0]  out_tag;

  // Issuing side: drives requests, consumes results
  modport master (
    output in_valid, in_data, in_shamt, in_mode, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );

  // Shift unit side
  modport slave (
    input  in_valid, in_data, in_shamt, in_mode, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );
endinterface

// File: rtl/pipelined_shift_unit.sv
// Pipelined barrel shifter: one barrel level per stage (LSB level first), each
// level registered. Modes: 00 SLL, 01 SRL, 10 SRA, 11 ROR. The pipeline stalls
// as a whole when the result register is full and not being consumed.
module pipelined_shift_unit #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH),
  parameter int TAGW  = 5
) (
  input logic                   clock,
  input logic                   reset_n,
  pipelined_shift_unit_if.slave bus
);
  localparam logic [1:0] MODE_SLL = 2'b00;
  localparam logic [1:0] MODE_SRL = 2'b01;
  localparam logic [1:0] MODE_SRA = 2'b10;
  localparam logic [1:0] MODE_ROR = 2'b11;

  // One barrel level: shift by amt when en is set. The SRA fill uses the sign
  // captured at stage 0, never the MSB of the partially shifted data.
  function automatic logic [WIDTH-1:0] shift_level(
    input logic [WIDTH-1:0] d,
    input logic             en,
    input logic [1:0]       mode,
    input logic             sign,
    input int               amt
  );
    logic [WIDTH-1:0] ones;
    logic [WIDTH-1:0] res;
    ones = {WIDTH{1'b1}};
    res  = d;
    if (en) begin
      case (mode)
        MODE_SLL: res = d << amt;
        MODE_SRL: res = d >> amt;
        MODE_SRA: res = (d >> amt) | (sign ? ~(ones >> amt) : {WIDTH{1'b0}});
        MODE_ROR: res = (d >> amt) | (d << (WIDTH - amt));
        default:  res = d;
      endcase
    end
    return res;
  endfunction

  // Per-stage state; shamt_q holds only the bits still to be applied (the
  // next level always consumes bit 0).
  logic [WIDTH-1:0] data_q  [SHW];
  logic [WIDTH-1:0] data_d  [SHW];
  logic [SHW-1:0]   shamt_q [SHW];
  logic [SHW-1:0]   shamt_d [SHW];
  logic [1:0]       mode_q  [SHW];
  logic [1:0]       mode_d  [SHW];
  logic             sign_q  [SHW];
  logic             sign_d  [SHW];
  logic [TAGW-1:0]  tag_q   [SHW];
  logic [TAGW-1:0]  tag_d   [SHW];
  logic             valid_q [SHW];
  logic             valid_d [SHW];

  logic             advance_s;

  assign advance_s     = ~valid_q[SHW-1] | bus.out_ready;
  assign bus.in_ready  = advance_s;
  assign bus.out_valid = valid_q[SHW-1];
  assign bus.out_data  = data_q[SHW-1];
  assign bus.out_tag   = tag_q[SHW-1];

  // Next state of every stage: all stages load together on advance, else hold
  always_comb begin
    for (int k = 0; k < SHW; k++) begin
      if (advance_s) begin
        if (k == 0) begin
          data_d[k]  = shift_level(bus.in_data, bus.in_shamt[0], bus.in_mode,
                                   bus.in_data[WIDTH-1], 32'd1);
          shamt_d[k] = bus.in_shamt >> 1'b1;
          mode_d[k]  = bus.in_mode;
          sign_d[k]  = bus.in_data[WIDTH-1];
          tag_d[k]   = bus.in_tag;
          valid_d[k] = bus.in_valid;
        end else begin
          data_d[k]  = shift_level(data_q[k-1], shamt_q[k-1][0], mode_q[k-1],
                                   sign_q[k-1], (32'd1 << k));
          shamt_d[k] = shamt_q[k-1] >> 1'b1;
          mode_d[k]  = mode_q[k-1];
          sign_d[k]  = sign_q[k-1];
          tag_d[k]   = tag_q[k-1];
          valid_d[k] = valid_q[k-1];
        end
      end else begin
        data_d[k]  = data_q[k];
        shamt_d[k] = shamt_q[k];
        mode_d[k]  = mode_q[k];
        sign_d[k]  = sign_q[k];
        tag_d[k]   = tag_q[k];
        valid_d[k] = valid_q[k];
      end
    end
  end

  // Stage registers; reset clears everything so no partial result survives
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < SHW; k++) begin
        data_q[k]  <= {WIDTH{1'b0}};
        shamt_q[k] <= {SHW{1'b0}};
        mode_q[k]  <= 2'b00;
        sign_q[k]  <= 1'b0;
        tag_q[k]   <= {TAGW{1'b0}};
        valid_q[k] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < SHW; k++) begin
        data_q[k]  <= data_d[k];
        shamt_q[k] <= shamt_d[k];
        mode_q[k]  <= mode_d[k];
        sign_q[k]  <= sign_d[k];
        tag_q[k]   <= tag_d[k];
        valid_q[k] <= valid_d[k];
      end
    end
  end
endmodule

// File: tb/tb_pipelined_shift_unit.sv
// Scoreboard bench for pipelined_shift_unit at WIDTH 32, 8 and 64.
module tb_pipelined_shift_unit;
  typedef struct {
    logic [63:0] data;
    logic [7:0]  tag;
    int          adv;
  } sb_t;

  logic clock;
  logic reset_n;
  int   n_checks = 0;
  int   n_errors = 0;

  sb_t  q32[$];
  sb_t  q8[$];
  sb_t  q64[$];
  sb_t  e32, e8, e64, n32, n8, n64;
  int   adv32 = 0;
  int   adv8  = 0;
  int   adv64 = 0;
  logic [63:0] exp_pending32;
  logic sweeping;

  pipelined_shift_unit_if #(.WIDTH(32), .TAGW(5)) b32 ();
  pipelined_shift_unit_if #(.WIDTH(8),  .TAGW(5)) b8 ();
  pipelined_shift_unit_if #(.WIDTH(64), .TAGW(5)) b64 ();

  pipelined_shift_unit #(.WIDTH(32), .TAGW(5)) u_dut32 (.clock(clock), .reset_n(reset_n), .bus(b32.slave));
  pipelined_shift_unit #(.WIDTH(8),  .TAGW(5)) u_dut8  (.clock(clock), .reset_n(reset_n), .bus(b8.slave));
  pipelined_shift_unit #(.WIDTH(64), .TAGW(5)) u_dut64 (.clock(clock), .reset_n(reset_n), .bus(b64.slave));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference shifter of width w (<= 64), evaluated directly on the whole amount
  function automatic logic [63:0] ref_shift(input logic [63:0] d_in, input int sh,
                                            input logic [1:0] mode, input int w);
    logic [63:0] mask, d, r;
    mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    d    = d_in & mask;
    case (mode)
      2'b00:   r = (d << sh) & mask;
      2'b01:   r = d >> sh;
      2'b10: begin
        r = d >> sh;
        if (d[w-1]) r = r | (mask & ~(mask >> sh));
      end
      default: r = ((d >> sh) | (d << (w - sh))) & mask;
    endcase
    return r;
  endfunction

  function automatic logic ready_of(input int w);
    case (w)
      8:       return b8.in_ready;
      64:      return b64.in_ready;
      default: return b32.in_ready;
    endcase
  endfunction

  // Hold the request until the unit takes it (bounded), then step past the edge
  task automatic wait_accept(input int w);
    int t = 0;
    @(negedge clock);
    while (!ready_of(w) && t < 200) begin
      @(negedge clock);
      t++;
    end
    check_val("accept_timeout", 64'(ready_of(w)), 64'd1);
    @(posedge clock);
    #1;
  endtask

  task automatic send32(input logic [31:0] d, input logic [4:0] sh, input logic [1:0] mode,
                        input logic [4:0] tag, input logic [31:0] exp);
    b32.in_valid  = 1'b1;
    b32.in_data   = d;
    b32.in_shamt  = sh;
    b32.in_mode   = mode;
    b32.in_tag    = tag;
    exp_pending32 = 64'(exp);
    wait_accept(32);
  endtask

  task automatic send32_model(input logic [31:0] d, input logic [4:0] sh, input logic [1:0] mode,
                              input logic [4:0] tag);
    logic [63:0] r;
    r = ref_shift(64'(d), int'(sh), mode, 32);
    send32(d, sh, mode, tag, r[31:0]);
  endtask

  task automatic drain();
    int t = 0;
    while ((q32.size() + q8.size() + q64.size()) != 0 && t < 1000) begin
      @(posedge clock);
      t++;
    end
    check_val("drain_timeout", 64'(q32.size() + q8.size() + q64.size()), 64'd0);
    @(posedge clock);
    #1;
  endtask

  task automatic sweep8(input int n);
    for (int i = 0; i < n; i++) begin
      b8.in_valid = 1'b1;
      b8.in_data  = 8'($urandom);
      b8.in_shamt = 3'($urandom);
      b8.in_mode  = 2'($urandom);
      b8.in_tag   = 5'(i);
      wait_accept(8);
      if ($urandom_range(0, 7) == 0) begin
        b8.in_valid = 1'b0;
        @(posedge clock);
        #1;
      end
    end
    b8.in_valid = 1'b0;
  endtask

  task automatic sweep64(input int n);
    for (int i = 0; i < n; i++) begin
      b64.in_valid = 1'b1;
      b64.in_data  = {$urandom, $urandom};
      b64.in_shamt = 6'($urandom);
      b64.in_mode  = 2'($urandom);
      b64.in_tag   = 5'(i);
      wait_accept(64);
      if ($urandom_range(0, 7) == 0) begin
        b64.in_valid = 1'b0;
        @(posedge clock);
        #1;
      end
    end
    b64.in_valid = 1'b0;
  endtask

  // 32-bit scoreboard: retire results, record accepts, count advancing edges
  always @(negedge clock) begin
    if (reset_n) begin
      if (b32.out_valid && b32.out_ready) begin
        check_val("sb32_has_entry", 64'(q32.size() != 0), 64'd1);
        if (q32.size() != 0) begin
          e32 = q32.pop_front();
          check_val("data32", 64'(b32.out_data), e32.data);
          check_val("tag32", 64'(b32.out_tag), 64'(e32.tag));
          check_val("latency32", 64'(adv32 - e32.adv), 64'd5);
        end
      end
      if (b32.in_valid && b32.in_ready) begin
        n32.data = exp_pending32;
        n32.tag  = 8'(b32.in_tag);
        n32.adv  = adv32;
        q32.push_back(n32);
      end
      if (b32.in_ready) adv32++;
    end
  end

  // 8-bit scoreboard
  always @(negedge clock) begin
    if (reset_n) begin
      if (b8.out_valid && b8.out_ready) begin
        check_val("sb8_has_entry", 64'(q8.size() != 0), 64'd1);
        if (q8.size() != 0) begin
          e8 = q8.pop_front();
          check_val("data8", 64'(b8.out_data), e8.data);
          check_val("tag8", 64'(b8.out_tag), 64'(e8.tag));
          check_val("latency8", 64'(adv8 - e8.adv), 64'd3);
        end
      end
      if (b8.in_valid && b8.in_ready) begin
        n8.data = ref_shift(64'(b8.in_data), int'(b8.in_shamt), b8.in_mode, 8);
        n8.tag  = 8'(b8.in_tag);
        n8.adv  = adv8;
        q8.push_back(n8);
      end
      if (b8.in_ready) adv8++;
    end
  end

  // 64-bit scoreboard
  always @(negedge clock) begin
    if (reset_n) begin
      if (b64.out_valid && b64.out_ready) begin
        check_val("sb64_has_entry", 64'(q64.size() != 0), 64'd1);
        if (q64.size() != 0) begin
          e64 = q64.pop_front();
          check_val("data64", b64.out_data, e64.data);
          check_val("tag64", 64'(b64.out_tag), 64'(e64.tag));
          check_val("latency64", 64'(adv64 - e64.adv), 64'd6);
        end
      end
      if (b64.in_valid && b64.in_ready) begin
        n64.data = ref_shift(b64.in_data, int'(b64.in_shamt), b64.in_mode, 64);
        n64.tag  = 8'(b64.in_tag);
        n64.adv  = adv64;
        q64.push_back(n64);
      end
      if (b64.in_ready) adv64++;
    end
  end

  initial begin
    logic [31:0] hd;
    logic [4:0]  ht;
    int          stale;
    int          t;

    reset_n       = 1'b0;
    sweeping      = 1'b0;
    exp_pending32 = 64'd0;
    b32.in_valid = 1'b0; b32.in_data = '0; b32.in_shamt = '0; b32.in_mode = '0; b32.in_tag = '0; b32.out_ready = 1'b0;
    b8.in_valid  = 1'b0; b8.in_data  = '0; b8.in_shamt  = '0; b8.in_mode  = '0; b8.in_tag  = '0; b8.out_ready  = 1'b0;
    b64.in_valid = 1'b0; b64.in_data = '0; b64.in_shamt = '0; b64.in_mode = '0; b64.in_tag = '0; b64.out_ready = 1'b0;
    #2;
    check_val("rst_out_valid", 64'(b32.out_valid), 64'd0);
    check_val("rst_out_data", 64'(b32.out_data), 64'd0);
    check_val("rst_out_tag", 64'(b32.out_tag), 64'd0);
    check_val("rst_in_ready", 64'(b32.in_ready), 64'd1);
    @(posedge clock);
    #1;
    reset_n       = 1'b1;
    b32.out_ready = 1'b1;
    b8.out_ready  = 1'b1;
    b64.out_ready = 1'b1;

    // Directed values and boundaries
    send32(32'h8000_0000, 5'd2,  2'b10, 5'd7,  32'hE000_0000);
    send32(32'h8000_0000, 5'd2,  2'b01, 5'd8,  32'h2000_0000);
    send32(32'h0000_0001, 5'd31, 2'b00, 5'd9,  32'h8000_0000);
    send32(32'h0000_0001, 5'd1,  2'b11, 5'd10, 32'h8000_0000);
    for (int m = 0; m < 4; m++) send32(32'hA5A5_F00F, 5'd0, 2'(m), 5'(11 + m), 32'hA5A5_F00F);
    send32(32'h8000_1234, 5'd31, 2'b10, 5'd15, 32'hFFFF_FFFF);
    send32(32'h7FFF_0000, 5'd31, 2'b10, 5'd16, 32'h0000_0000);
    send32(32'h0F0F_0003, 5'd4,  2'b11, 5'd17, 32'h30F0_F000);
    b32.in_valid = 1'b0;
    drain();

    // Back-to-back throughput, tags 0..7, mixed modes
    for (int i = 0; i < 8; i++) send32_model($urandom, 5'($urandom), 2'(i), 5'(i));
    b32.in_valid = 1'b0;
    drain();

    // Backpressure: stall a full pipe for three cycles
    fork
      begin
        for (int i = 0; i < 12; i++) send32_model($urandom, 5'($urandom), 2'($urandom), 5'(i));
        b32.in_valid = 1'b0;
      end
      begin
        repeat (8) @(negedge clock);
        @(posedge clock);
        #1;
        b32.out_ready = 1'b0;
        hd = b32.out_data;
        ht = b32.out_tag;
        repeat (3) begin
          @(negedge clock);
          check_val("stall_in_ready", 64'(b32.in_ready), 64'd0);
          check_val("stall_out_valid", 64'(b32.out_valid), 64'd1);
          check_val("stall_data_hold", 64'(b32.out_data), 64'(hd));
          check_val("stall_tag_hold", 64'(b32.out_tag), 64'(ht));
        end
        @(posedge clock);
        #1;
        b32.out_ready = 1'b1;
      end
    join
    drain();

    // Reset with three requests in flight
    b32.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send32_model(32'h1234_5678, 5'(i), 2'b00, 5'(21 + i));
    b32.in_valid = 1'b0;
    t = 0;
    @(negedge clock);
    while (!b32.out_valid && t < 20) begin
      @(negedge clock);
      t++;
    end
    check_val("fill_before_reset", 64'(b32.out_valid), 64'd1);
    #1;
    reset_n = 1'b0;
    #1;
    check_val("midrst_out_valid", 64'(b32.out_valid), 64'd0);
    check_val("midrst_out_data", 64'(b32.out_data), 64'd0);
    check_val("midrst_out_tag", 64'(b32.out_tag), 64'd0);
    check_val("midrst_in_ready", 64'(b32.in_ready), 64'd1);
    #2;
    reset_n = 1'b1;
    q32.delete();
    @(posedge clock);
    #1;
    b32.out_ready = 1'b1;
    stale = 0;
    repeat (10) begin
      @(negedge clock);
      if (b32.out_valid) stale++;
    end
    check_val("no_stale_after_reset", 64'(stale), 64'd0);
    @(posedge clock);
    #1;
    send32(32'h0000_00F0, 5'd4, 2'b01, 5'd30, 32'h0000_000F);
    b32.in_valid = 1'b0;
    drain();

    // Random sweeps at WIDTH 8 and 64 with random consumer backpressure
    sweeping = 1'b1;
    fork
      begin
        fork
          sweep8(10000);
          sweep64(10000);
        join
        sweeping = 1'b0;
      end
      begin
        while (sweeping) begin
          @(posedge clock);
          #1;
          b8.out_ready  = ($urandom_range(0, 3) != 0);
          b64.out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    b8.out_ready  = 1'b1;
    b64.out_ready = 1'b1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
